// File: rtl/minirisc_irq_pkg.sv
// Shared definitions for the MiniRISC vectored interrupt controller:
// FSM encoding, config register map, channel/bus widths and a vector helper.
package minirisc_irq_pkg;

  localparam int unsigned MAX_IRQ = 8;
  localparam int unsigned IDX_W   = $clog2(MAX_IRQ);
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned DATA_W  = 8;

  localparam logic [ADDR_W-1:0] REG_ENABLE     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] REG_EDGE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] REG_PENDING    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] REG_IN_SERVICE = ADDR_W'(3);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  // Channel vector: base plus index, wrapping at 8 bits.
  function automatic logic [DATA_W-1:0] vec_of(input logic [DATA_W-1:0] base,
                                               input logic [IDX_W-1:0]  idx);
    return base + DATA_W'(idx);
  endfunction

endpackage

// File: rtl/minirisc_irq_ctrl_if.sv
// Config bus and CPU interrupt handshake of the interrupt controller.
// master: CPU/config side (drives cfg_*, flag_ie, int_ack, int_ret)
// slave : controller side (drives cfg_dout, int_req, int_vector, nest_err)
interface minirisc_irq_ctrl_if;
  import minirisc_irq_pkg::*;

  logic              cfg_wr;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_din;
  logic [DATA_W-1:0] cfg_dout;
  logic              flag_ie;
  logic              int_req;
  logic [DATA_W-1:0] int_vector;
  logic              int_ack;
  logic              int_ret;
  logic              nest_err;

  modport master (
    output cfg_wr, cfg_addr, cfg_din, flag_ie, int_ack, int_ret,
    input  cfg_dout, int_req, int_vector, nest_err
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_din, flag_ie, int_ack, int_ret,
    output cfg_dout, int_req, int_vector, nest_err
  );

endinterface

// File: rtl/minirisc_irq_prio_enc.sv
// Lowest-index-wins priority encoder.
// req     : request vector, bit 0 highest priority
// valid_c : any request set (combinational)
// idx_c   : index of the lowest set bit, 0 when none (combinational)
module minirisc_irq_prio_enc
  import minirisc_irq_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     req,
  output logic             valid_c,
  output logic [IDX_W-1:0] idx_c
);

  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (req[i] && !valid_c) begin
        valid_c = 1'b1;
        idx_c   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/minirisc_irq_ctrl.sv
// Vectored, prioritised interrupt controller for MiniRISC with a nested
// in-service stack. Channel 0 is highest priority.
// Build option: IRQ_NESTING_EN -- when defined, the in-service stack holds
// NEST_DEPTH entries and strictly higher channels preempt; otherwise the
// stack holds one entry and nothing is requested while it is occupied.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   irq_in     : raw asynchronous peripheral lines
//   bus        : config registers (ENABLE, EDGE, PENDING W1C, IN_SERVICE RO)
//                and CPU handshake (flag_ie, int_req/int_vector, int_ack,
//                int_ret, sticky nest_err)
module minirisc_irq_ctrl
  import minirisc_irq_pkg::*;
#(
  parameter int unsigned       NUM_IRQ    = 4,
  parameter int unsigned       NEST_DEPTH = 4,
  parameter logic [DATA_W-1:0] VEC_BASE   = 8'h10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  minirisc_irq_ctrl_if.slave bus
);

`ifdef IRQ_NESTING_EN
  localparam bit NEST_EN = 1'b1;
`else
  localparam bit NEST_EN = 1'b0;
`endif

  localparam int unsigned DEPTH = NEST_EN ? NEST_DEPTH : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH + 1);

  logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d, en_q, edge_q;
  logic [NUM_IRQ-1:0] rise, w1c, ack_clr, below, elig, in_svc;

  logic [IDX_W-1:0]   stk_q [DEPTH];
  logic [PTR_W-1:0]   ptr_q, ptr_mid;
  logic [IDX_W-1:0]   top_idx;
  logic               stk_empty, stk_full;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   req_idx_q;
  logic [DATA_W-1:0]  vec_q;
  logic               nest_err_q;

  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic               latched_live;
  logic               take, push;
  logic               pop, push_ok, ret_err, ack_err;

  logic               unused_cfg;
  assign unused_cfg = ^bus.cfg_din;

  // Input synchronisers, edge history, config registers and pending state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
      if (bus.cfg_wr && bus.cfg_addr == REG_ENABLE) en_q <= bus.cfg_din[NUM_IRQ-1:0];
      if (bus.cfg_wr && bus.cfg_addr == REG_EDGE)   edge_q <= bus.cfg_din[NUM_IRQ-1:0];
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign w1c  = (bus.cfg_wr && bus.cfg_addr == REG_PENDING) ? bus.cfg_din[NUM_IRQ-1:0] : '0;

  // Edge channels latch rises (set beats clear); level channels follow the line
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (edge_q[i]) pend_d[i] = rise[i] | (pend_q[i] & ~(w1c[i] | ack_clr[i]));
      else           pend_d[i] = sync2_q[i];
    end
  end

  // Stack status: top entry and bitmap of everything in service
  assign stk_empty = (ptr_q == '0);
  assign stk_full  = (ptr_q == PTR_W'(DEPTH));

  always_comb begin
    top_idx = '0;
    in_svc  = '0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      if (PTR_W'(j + 1) == ptr_q) top_idx = stk_q[j];
      if (PTR_W'(j) < ptr_q) begin
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
          if (stk_q[j] == IDX_W'(i)) in_svc[i] = 1'b1;
        end
      end
    end
  end

  // Only channels strictly above the top of stack in priority may interrupt
  always_comb begin
    below        = '0;
    ack_clr      = '0;
    latched_live = 1'b0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      below[i] = stk_empty || (IDX_W'(i) < top_idx);
      if (req_idx_q == IDX_W'(i)) begin
        ack_clr[i]   = push_ok;
        latched_live = pend_q[i] & en_q[i];
      end
    end
  end

  assign elig = pend_q & en_q & below;

  minirisc_irq_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
    .req     (elig),
    .valid_c (win_valid),
    .idx_c   (win_idx)
  );

  // Request FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request FSM next state; ack wins over withdrawal in REQ
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.flag_ie && win_valid && !stk_full) begin
          state_d = S_REQ;
          take    = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.int_ack) begin
          state_d = S_IDLE;
          push    = 1'b1;
        end else if (!bus.flag_ie || !latched_live) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Winner index and its vector are frozen for the whole request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_idx_q <= '0;
      vec_q     <= VEC_BASE;
    end else if (take) begin
      req_idx_q <= win_idx;
      vec_q     <= vec_of(VEC_BASE, win_idx);
    end
  end

  // Pop happens before push, so ret+ack together replaces the top entry
  assign pop     = bus.int_ret && !stk_empty;
  assign ret_err = bus.int_ret && stk_empty;
  assign push_ok = push && (!stk_full || pop);
  assign ack_err = push && stk_full && !pop;
  assign ptr_mid = ptr_q - PTR_W'(pop);

  // In-service stack and sticky nesting error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      nest_err_q <= 1'b0;
      for (int j = 0; j < int'(DEPTH); j++) stk_q[j] <= '0;
    end else begin
      ptr_q      <= ptr_mid + PTR_W'(push_ok);
      nest_err_q <= nest_err_q | ret_err | ack_err;
      if (push_ok) begin
        for (int j = 0; j < int'(DEPTH); j++) begin
          if (PTR_W'(j) == ptr_mid) stk_q[j] <= req_idx_q;
        end
      end
    end
  end

  // Combinational register read-back
  always_comb begin
    bus.cfg_dout = '0;
    case (bus.cfg_addr)
      REG_ENABLE:     bus.cfg_dout = DATA_W'(en_q);
      REG_EDGE:       bus.cfg_dout = DATA_W'(edge_q);
      REG_PENDING:    bus.cfg_dout = DATA_W'(pend_q);
      REG_IN_SERVICE: bus.cfg_dout = DATA_W'(in_svc);
      default:        bus.cfg_dout = '0;
    endcase
  end

  assign bus.int_req    = (state_q == S_REQ);
  assign bus.int_vector = vec_q;
  assign bus.nest_err   = nest_err_q;

endmodule

// File: tb/tb_minirisc_irq_ctrl.sv
// Self-checking bench for minirisc_irq_ctrl (4 channels, stack depth 2 when
// IRQ_NESTING_EN is defined). Expected vectors are queued when an interrupt
// line is driven and popped when the controller raises int_req.
module tb_minirisc_irq_ctrl;
  import minirisc_irq_pkg::*;

  localparam int unsigned NUM_IRQ    = 4;
  localparam int unsigned NEST_DEPTH = 2;
  localparam logic [7:0]  VEC_BASE   = 8'h10;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq;

  minirisc_irq_ctrl_if bus ();

  minirisc_irq_ctrl #(
    .NUM_IRQ    (NUM_IRQ),
    .NEST_DEPTH (NEST_DEPTH),
    .VEC_BASE   (VEC_BASE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (irq),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    bus.cfg_wr   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_din  = d;
    step();
    bus.cfg_wr   = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
    bus.cfg_addr = a;
    #1;
    d = bus.cfg_dout;
  endtask

  task automatic pulse_irq(input logic [NUM_IRQ-1:0] m);
    irq = m;
    step();
    irq = '0;
  endtask

  task automatic ack_pulse();
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
  endtask

  task automatic ret_pulse();
    bus.int_ret = 1'b1;
    step();
    bus.int_ret = 1'b0;
  endtask

  task automatic wait_req(output bit ok, output logic [7:0] vec);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.int_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    vec = bus.int_vector;
  endtask

  task automatic quiet(input int n, output bit seen);
    seen = 1'b0;
    repeat (n) begin
      step();
      if (bus.int_req !== 1'b0) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req: got %0b want 0", bus.int_req); end
    checks++; if (bus.int_vector !== 8'h10) begin errors++; $display("FAIL reset_vector: got %h want 10", bus.int_vector); end
    checks++; if (bus.nest_err !== 1'b0) begin errors++; $display("FAIL reset_nest_err: got %0b want 0", bus.nest_err); end
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h want 00", a, d); end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_edge_latency();
    logic [7:0] d, exp;
    cfg_write(REG_ENABLE, 8'h01);
    cfg_write(REG_EDGE, 8'h01);
    bus.flag_ie = 1'b1;
    exp_q.push_back(8'h10);
    pulse_irq(4'b0001);     // E0
    step();                 // E1
    step();                 // E2
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL lat_early_req: got %0b want 0", bus.int_req); end
    read_reg(REG_PENDING, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL lat_pending: got %h want 01", d); end
    step();                 // E3
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL lat_req: got %0b want 1", bus.int_req); end
    exp = exp_q.pop_front();
    checks++; if (bus.int_vector !== exp) begin errors++; $display("FAIL lat_vector: got %h want %h", bus.int_vector, exp); end
    ack_pulse();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL lat_ack_drop: got %0b want 0", bus.int_req); end
    read_reg(REG_PENDING, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL lat_ack_pending: got %h want 00", d); end
    read_reg(REG_IN_SERVICE, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL lat_in_service: got %h want 01", d); end
    ret_pulse();
    read_reg(REG_IN_SERVICE, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL lat_ret_in_service: got %h want 00", d); end
  endtask

  task automatic test_level_drop();
    bit ok;
    logic [7:0] d, vec, exp;
    cfg_write(REG_ENABLE, 8'h02);
    cfg_write(REG_EDGE, 8'h00);
    irq = 4'b0010;
    exp_q.push_back(8'h11);
    wait_req(ok, vec);
    exp = exp_q.pop_front();
    checks++; if (!ok || vec !== exp) begin errors++; $display("FAIL level_req: req=%0b vector=%h want %h", ok, vec, exp); end
    irq = '0;
    for (int i = 0; i < 8 && bus.int_req === 1'b1; i++) step();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL level_withdraw: got %0b want 0", bus.int_req); end
    read_reg(REG_IN_SERVICE, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL level_in_service: got %h want 00", d); end
    checks++; if (bus.nest_err !== 1'b0) begin errors++; $display("FAIL level_nest_err: got %0b want 0", bus.nest_err); end
  endtask

  task automatic test_w1c();
    logic [7:0] d;
    cfg_write(REG_ENABLE, 8'h00);
    cfg_write(REG_EDGE, 8'h01);
    pulse_irq(4'b0001);
    step();
    step();
    read_reg(REG_PENDING, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL w1c_set: got %h want 01", d); end
    cfg_write(REG_PENDING, 8'h01);
    read_reg(REG_PENDING, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL w1c_clear: got %h want 00", d); end
    // W1C lands on the same edge as the synchronised rise
    pulse_irq(4'b0001);
    step();
    cfg_write(REG_PENDING, 8'h01);
    read_reg(REG_PENDING, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL w1c_set_wins: got %h want 01", d); end
    cfg_write(REG_PENDING, 8'h01);
    cfg_write(REG_EDGE, 8'h00);
    irq = 4'b0010;
    repeat (3) step();
    read_reg(REG_PENDING, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL w1c_level_set: got %h want 02", d); end
    cfg_write(REG_PENDING, 8'h02);
    read_reg(REG_PENDING, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL w1c_level_ignored: got %h want 02", d); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL w1c_disabled_req: got %0b want 0", bus.int_req); end
    irq = '0;
    repeat (3) step();
    read_reg(REG_PENDING, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL w1c_level_clear: got %h want 00", d); end
  endtask

  task automatic test_priority();
    bit ok, seen;
    logic [7:0] d, vec, exp;
    cfg_write(REG_ENABLE, 8'h0F);
    cfg_write(REG_EDGE, 8'h0F);
    exp_q.push_back(8'h12);
    pulse_irq(4'b0100);
    wait_req(ok, vec);
    exp = exp_q.pop_front();
    checks++; if (!ok || vec !== exp) begin errors++; $display("FAIL prio_ch2: req=%0b vector=%h want %h", ok, vec, exp); end
    ack_pulse();
    pulse_irq(4'b1010);
`ifdef IRQ_NESTING_EN
    exp_q.push_back(8'h11);
    wait_req(ok, vec);
    exp = exp_q.pop_front();
    checks++; if (!ok || vec !== exp) begin errors++; $display("FAIL prio_ch1_preempt: req=%0b vector=%h want %h", ok, vec, exp); end
    ack_pulse();
    read_reg(REG_IN_SERVICE, d);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL prio_in_service: got %h want 06", d); end
    quiet(6, seen);
    checks++; if (seen) begin errors++; $display("FAIL prio_ch3_blocked_full: got req want none"); end
    ret_pulse();
    quiet(6, seen);
    checks++; if (seen) begin errors++; $display("FAIL prio_ch3_blocked_ch2: got req want none"); end
    ret_pulse();
`else
    quiet(6, seen);
    checks++; if (seen) begin errors++; $display("FAIL prio_blocked_in_service: got req want none"); end
    ret_pulse();
    exp_q.push_back(8'h11);
    wait_req(ok, vec);
    exp = exp_q.pop_front();
    checks++; if (!ok || vec !== exp) begin errors++; $display("FAIL prio_ch1_after_ret: req=%0b vector=%h want %h", ok, vec, exp); end
    ack_pulse();
    read_reg(REG_IN_SERVICE, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL prio_in_service: got %h want 02", d); end
    ret_pulse();
`endif
    exp_q.push_back(8'h13);
    wait_req(ok, vec);
    exp = exp_q.pop_front();
    checks++; if (!ok || vec !== exp) begin errors++; $display("FAIL prio_ch3_last: req=%0b vector=%h want %h", ok, vec, exp); end
    ack_pulse();
    ret_pulse();
    read_reg(REG_IN_SERVICE, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL prio_final_in_service: got %h want 00", d); end
  endtask

  task automatic test_depth();
    bit ok, seen;
    logic [7:0] d, vec, exp, blk, pend_exp;
    exp_q.push_back(8'h13);
    pulse_irq(4'b1000);
    wait_req(ok, vec);
    exp = exp_q.pop_front();
    checks++; if (!ok || vec !== exp) begin errors++; $display("FAIL depth_ch3: req=%0b vector=%h want %h", ok, vec, exp); end
    ack_pulse();
`ifdef IRQ_NESTING_EN
    exp_q.push_back(8'h12);
    pulse_irq(4'b0100);
    wait_req(ok, vec);
    exp = exp_q.pop_front();
    checks++; if (!ok || vec !== exp) begin errors++; $display("FAIL depth_ch2: req=%0b vector=%h want %h", ok, vec, exp); end
    ack_pulse();
    blk = 8'h02;
    pend_exp = 8'h0C;
`else
    blk = 8'h04;
    pend_exp = 8'h08;
`endif
    read_reg(REG_IN_SERVICE, d);
    checks++; if (d !== pend_exp) begin errors++; $display("FAIL depth_in_service: got %h want %h", d, pend_exp); end
    pulse_irq(NUM_IRQ'(blk));
    quiet(6, seen);
    checks++; if (seen) begin errors++; $display("FAIL depth_full_blocked: got req want none"); end
    read_reg(REG_PENDING, d);
    checks++; if (d !== blk) begin errors++; $display("FAIL depth_pending: got %h want %h", d, blk); end
    exp_q.push_back((blk == 8'h02) ? 8'h11 : 8'h12);
    bus.int_ret = 1'b1;
    repeat (3) step();
    bus.int_ret = 1'b0;
    checks++; if (bus.nest_err !== 1'b1) begin errors++; $display("FAIL depth_nest_err: got %0b want 1", bus.nest_err); end
    read_reg(REG_IN_SERVICE, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL depth_empty: got %h want 00", d); end
    wait_req(ok, vec);
    exp = exp_q.pop_front();
    checks++; if (!ok || vec !== exp) begin errors++; $display("FAIL depth_after_pop: req=%0b vector=%h want %h", ok, vec, exp); end
    cfg_write(REG_PENDING, blk);
    step();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL depth_w1c_withdraw: got %0b want 0", bus.int_req); end
  endtask

  task automatic test_ack_ret();
    bit ok;
    logic [7:0] d, vec, exp;
`ifdef IRQ_NESTING_EN
    exp_q.push_back(8'h13);
    pulse_irq(4'b1000);
    wait_req(ok, vec);
    exp = exp_q.pop_front();
    checks++; if (!ok || vec !== exp) begin errors++; $display("FAIL ackret_ch3: req=%0b vector=%h want %h", ok, vec, exp); end
    ack_pulse();
`endif
    exp_q.push_back(8'h10);
    pulse_irq(4'b0001);
    wait_req(ok, vec);
    exp = exp_q.pop_front();
    checks++; if (!ok || vec !== exp) begin errors++; $display("FAIL ackret_ch0: req=%0b vector=%h want %h", ok, vec, exp); end
    bus.int_ack = 1'b1;
    bus.int_ret = 1'b1;
    step();
    bus.int_ack = 1'b0;
    bus.int_ret = 1'b0;
    read_reg(REG_IN_SERVICE, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL ackret_in_service: got %h want 01", d); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL ackret_req_drop: got %0b want 0", bus.int_req); end
    ret_pulse();
    read_reg(REG_IN_SERVICE, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ackret_final: got %h want 00", d); end
  endtask

  task automatic test_reset_mid_req();
    bit ok;
    logic [7:0] d, vec, exp;
    exp_q.push_back(8'h12);
    pulse_irq(4'b0100);
    wait_req(ok, vec);
    exp = exp_q.pop_front();
    checks++; if (!ok || vec !== exp) begin errors++; $display("FAIL rstreq_ch2: req=%0b vector=%h want %h", ok, vec, exp); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL rstreq_int_req: got %0b want 0", bus.int_req); end
    checks++; if (bus.int_vector !== 8'h10) begin errors++; $display("FAIL rstreq_vector: got %h want 10", bus.int_vector); end
    checks++; if (bus.nest_err !== 1'b0) begin errors++; $display("FAIL rstreq_nest_err: got %0b want 0", bus.nest_err); end
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rstreq_reg%0d: got %h want 00", a, d); end
    end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n        = 1'b0;
    irq          = '0;
    bus.cfg_wr   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_din  = '0;
    bus.flag_ie  = 1'b0;
    bus.int_ack  = 1'b0;
    bus.int_ret  = 1'b0;
    test_reset();
    test_edge_latency();
    test_level_drop();
    test_w1c();
    test_priority();
    test_depth();
    test_ack_ret();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
